mux_sel_buffer_in_reg: RTL

- Registered, parametrised successor of the interpolation/external-sample selector feeding the sample buffer.
- Selects one of N_SRC sample streams and forwards it through a one-entry output register with valid/ready handshakes.
- A select change is applied only after the output register drains, so samples from two sources never interleave.
- Counts the samples accepted since the last source switch.

---
 rtl/mux_sel_buffer_in_reg.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mux_sel_buffer_in_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_buffer_in_reg
// Purpose  : Selects one of N_SRC sample streams and forwards it through a
//            one-entry output register with valid/ready handshakes. A source
//            switch waits for the output register to drain, so samples from
//            two sources never interleave. Counts the samples accepted since
//            the last completed switch.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            data_in/valid_in  - packed source samples and per-source valid
//            ready_in          - per-source ready (only the routed source)
//            select/select_load- requested source index and load strobe
//            data_out/valid_out/ready_out - registered output handshake
//            active_sel        - source currently routed
//            switching         - high while draining before a switch
//            sample_count      - saturating count of accepted samples
//            sel_err           - sticky out-of-range select flag
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_buffer_in_reg #(
  parameter int DATA_WIDTH  = 14,
  parameter int N_SRC       = 2,
  parameter int SEL_WIDTH   = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC*DATA_WIDTH-1:0]   data_in,
  input  logic [N_SRC-1:0]              valid_in,
  output logic [N_SRC-1:0]              ready_in,
  input  logic [SEL_WIDTH-1:0]          select,
  input  logic                          select_load,
  output logic signed [DATA_WIDTH-1:0]  data_out,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [SEL_WIDTH-1:0]          active_sel,
  output logic                          switching,
  output logic [COUNT_WIDTH-1:0]        sample_count,
  output logic                          sel_err
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SEL_WIDTH-1:0]    r_pending;
  logic [SEL_WIDTH-1:0]    r_active_sel;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    r_sel_err;

  logic [DATA_WIDTH-1:0]   w_src [N_SRC];
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_sel_valid;
  logic                    w_can_load;
  logic                    w_in_xfer;
  logic                    w_out_xfer;
  logic                    w_sel_oob;
  logic                    w_sel_legal;
  logic                    w_pending_load;
  logic                    w_drain_done;

  // Unpack the flat source bus into one word per source.
  generate
    for (genvar k = 0; k < N_SRC; k++) begin : g_src
      assign w_src[k] = data_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Route the active source's data and valid.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (r_active_sel == SEL_WIDTH'(k)) begin
        w_sel_data  = w_src[k];
        w_sel_valid = valid_in[k];
      end
    end
  end

  assign w_can_load  = !r_valid || ready_out;
  assign w_out_xfer  = r_valid && ready_out;
  assign w_in_xfer   = (r_state == ST_RUN) && w_sel_valid && w_can_load;
  assign w_sel_oob   = 32'(select) >= N_SRC;
  assign w_sel_legal = !w_sel_oob;

  // Ready depends only on state, the output register and the route; never
  // on valid_in, so no combinational loop through upstream logic.
  always_comb begin
    ready_in = '0;
    if (r_state == ST_RUN) begin
      for (int k = 0; k < N_SRC; k++) begin
        if (r_active_sel == SEL_WIDTH'(k)) begin
          ready_in[k] = w_can_load;
        end
      end
    end
  end

  // Next-state logic. In DRAIN a fresh legal request re-arms the pending
  // index and defers completion by one cycle so the newest request wins.
  always_comb begin
    w_state_nxt    = r_state;
    w_pending_load = 1'b0;
    w_drain_done   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (select_load && w_sel_legal && (select != r_active_sel)) begin
          w_state_nxt    = ST_DRAIN;
          w_pending_load = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (select_load && w_sel_legal) begin
          w_pending_load = 1'b1;
        end else if (!r_valid || w_out_xfer) begin
          w_drain_done = 1'b1;
          w_state_nxt  = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending    <= '0;
      r_active_sel <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_count      <= '0;
      r_sel_err    <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_data  <= w_sel_data;
        r_valid <= 1'b1;
        if (!(&r_count)) begin
          r_count <= r_count + 1'b1;
        end
      end else if (w_out_xfer) begin
        r_valid <= 1'b0;
      end

      if (w_pending_load) begin
        r_pending <= select;
      end

      if (w_drain_done) begin
        r_active_sel <= r_pending;
        r_count      <= '0;
        r_valid      <= 1'b0;
      end

      if (select_load && w_sel_oob) begin
        r_sel_err <= 1'b1;
      end
    end
  end

  assign data_out     = r_data;
  assign valid_out    = r_valid;
  assign active_sel   = r_active_sel;
  assign switching    = (r_state == ST_DRAIN);
  assign sample_count = r_count;
  assign sel_err      = r_sel_err;

endmodule
`default_nettype wire
